// File: rtl/prbs_checker_if.sv
// Stream-side bundle of the PRBS checker: received bit stream in, lock/error status out.
// The checker itself uses the slave modport; the stream source/observer uses master.
interface prbs_checker_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             din_valid;
  logic             din;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic             lock_lost;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output din_valid,
    output din,
    output clr_err,
    input  locked,
    input  err_pulse,
    input  lock_lost,
    input  err_cnt
  );

  modport slave (
    input  din_valid,
    input  din,
    input  clr_err,
    output locked,
    output err_pulse,
    output lock_lost,
    output err_cnt
  );

endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 8-bit XNOR PRBS (taps 7,5,4): seeds, verifies, then
// flywheels on its own prediction while counting bit errors and watching for loss of sync.
module prbs_checker #(
  parameter int unsigned LOCK_MATCHES = 16,
  parameter int unsigned WIN_LEN      = 32,
  parameter int unsigned LOSS_ERRS    = 4,
  parameter int unsigned CNT_W        = 16
) (
  input logic        clk,
  input logic        rst,
  prbs_checker_if.slave bus
);

  typedef enum logic [1:0] {StSeed, StVerify, StLocked} state_e;

  localparam logic [7:0] MatchLast = 8'(LOCK_MATCHES - 1);
  localparam logic [7:0] WinLast   = 8'(WIN_LEN - 1);
  localparam logic [7:0] LossErrs  = 8'(LOSS_ERRS);

  state_e           state_q, state_d;
  logic [7:0]       hist_q, hist_d;
  logic [2:0]       seed_cnt_q, seed_cnt_d;
  logic [7:0]       match_cnt_q, match_cnt_d;
  logic [7:0]       win_cnt_q, win_cnt_d;
  logic [7:0]       win_err_q, win_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             lock_lost_q, lock_lost_d;

  logic       pred;
  logic       mismatch;
  logic [7:0] win_err_inc;

  assign pred        = ~(hist_q[7] ^ hist_q[5] ^ hist_q[4]);
  assign mismatch    = (bus.din != pred);
  assign win_err_inc = win_err_q + 8'(mismatch);

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    lock_lost_d = 1'b0;

    if (bus.din_valid) begin
      case (state_q)
        StSeed: begin
          hist_d = {hist_q[6:0], bus.din};
          if (seed_cnt_q == 3'd7) begin
            state_d     = StVerify;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            seed_cnt_d = seed_cnt_q + 3'd1;
          end
        end

        StVerify: begin
          // History always takes the line bit, so a mismatch simply re-seeds in place.
          hist_d = {hist_q[6:0], bus.din};
          if (!mismatch) begin
            if (match_cnt_q == MatchLast) begin
              state_d     = StLocked;
              match_cnt_d = '0;
              win_cnt_d   = '0;
              win_err_d   = '0;
            end else begin
              match_cnt_d = match_cnt_q + 8'd1;
            end
          end else begin
            match_cnt_d = '0;
          end
        end

        StLocked: begin
          // Flywheel on the prediction so one line error costs exactly one count.
          hist_d = {hist_q[6:0], pred};
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != {CNT_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + CNT_W'(1);
            end
          end
          if (win_err_inc == LossErrs) begin
            state_d     = StSeed;
            seed_cnt_d  = '0;
            lock_lost_d = 1'b1;
            win_cnt_d   = '0;
            win_err_d   = '0;
          end else if (win_cnt_q == WinLast) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 8'd1;
            win_err_d = win_err_inc;
          end
        end

        default: begin
          state_d    = StSeed;
          seed_cnt_d = '0;
        end
      endcase
    end

    if (bus.clr_err) begin
      err_cnt_d = '0;
    end

    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StSeed;
      hist_q      <= 8'h00;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: two instances (16-bit and 4-bit error counters) on the same stream,
// checked every cycle against a bit-queue reference model plus literal expectations.
module tb_prbs_checker;

  localparam int unsigned LOCK_MATCHES = 16;
  localparam int unsigned WIN_LEN      = 32;
  localparam int unsigned LOSS_ERRS    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  prbs_checker_if #(.CNT_W(16)) bus_a ();
  prbs_checker_if #(.CNT_W(4))  bus_b ();

  assign bus_b.din_valid = bus_a.din_valid;
  assign bus_b.din       = bus_a.din;
  assign bus_b.clr_err   = bus_a.clr_err;

  prbs_checker #(
    .LOCK_MATCHES(LOCK_MATCHES), .WIN_LEN(WIN_LEN), .LOSS_ERRS(LOSS_ERRS), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  prbs_checker #(
    .LOCK_MATCHES(LOCK_MATCHES), .WIN_LEN(WIN_LEN), .LOSS_ERRS(LOSS_ERRS), .CNT_W(4)
  ) dut4 (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: last 8 history bits as a queue (oldest first), mode 0/1/2 = seed/verify/locked.
  bit m_h[$];
  int m_mode, m_seed, m_match, m_wbits, m_werrs, m_cnt16, m_cnt4;
  bit n_locked, n_pulse, n_lost;
  int n_cnt16, n_cnt4;
  bit exp_locked, exp_pulse, exp_lost;
  int exp_cnt16, exp_cnt4;
  bit model_on = 1'b0;

  task automatic model_reset();
    m_h = {};
    for (int i = 0; i < 8; i++) m_h.push_back(1'b0);
    m_mode = 0; m_seed = 0; m_match = 0; m_wbits = 0; m_werrs = 0;
    m_cnt16 = 0; m_cnt4 = 0;
    exp_locked = 0; exp_pulse = 0; exp_lost = 0; exp_cnt16 = 0; exp_cnt4 = 0;
  endtask

  task automatic model_step(input bit v, input bit d, input bit c);
    bit p;
    n_pulse = 0;
    n_lost  = 0;
    if (!rst) begin
      n_locked = 0; n_cnt16 = 0; n_cnt4 = 0;
      return;
    end
    if (v) begin
      p = ~(m_h[0] ^ m_h[2] ^ m_h[3]);
      if (m_mode == 0) begin
        m_h.push_back(d);
        m_seed++;
        if (m_seed == 8) begin m_mode = 1; m_match = 0; end
      end else if (m_mode == 1) begin
        m_h.push_back(d);
        if (d == p) begin
          m_match++;
          if (m_match == LOCK_MATCHES) begin m_mode = 2; m_wbits = 0; m_werrs = 0; end
        end else begin
          m_match = 0;
        end
      end else begin
        m_h.push_back(p);
        m_wbits++;
        if (d != p) begin
          n_pulse = 1;
          m_werrs++;
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt4 < 15) m_cnt4++;
        end
        if (m_werrs == LOSS_ERRS) begin
          m_mode = 0; m_seed = 0; n_lost = 1;
        end else if (m_wbits == WIN_LEN) begin
          m_wbits = 0; m_werrs = 0;
        end
      end
      void'(m_h.pop_front());
    end
    if (c) begin m_cnt16 = 0; m_cnt4 = 0; end
    n_locked = (m_mode == 2);
    n_cnt16  = m_cnt16;
    n_cnt4   = m_cnt4;
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      chk("locked", bus_a.locked, exp_locked);
      chk("err_pulse", bus_a.err_pulse, exp_pulse);
      chk("lock_lost", bus_a.lock_lost, exp_lost);
      chk("err_cnt16", bus_a.err_cnt, exp_cnt16);
      chk("locked_w4", bus_b.locked, exp_locked);
      chk("err_cnt4", bus_b.err_cnt, exp_cnt4);
    end
  end

  // Generator: 8-bit XNOR PRBS, newest bit at g[0].
  logic [7:0] g;
  task automatic gen_next(output bit b);
    g = {g[6:0], ~(g[7] ^ g[5] ^ g[4])};
    b = g[0];
  endtask

  // One clock cycle: drive, advance the model, publish its outputs at the edge.
  task automatic send(input bit v, input bit d, input bit c);
    bus_a.din_valid = v;
    bus_a.din       = d;
    bus_a.clr_err   = c;
    model_step(v, d, c);
    @(posedge clk);
    exp_locked = n_locked; exp_pulse = n_pulse; exp_lost = n_lost;
    exp_cnt16 = n_cnt16; exp_cnt4 = n_cnt4;
    #1;
    bus_a.din_valid = 1'b0;
    bus_a.clr_err   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    send(0, 0, 0);
    send(0, 0, 0);
    rst = 1'b1;
    g = 8'h00;
  endtask

  task automatic lock_clean(input string tag);
    bit b;
    for (int i = 1; i <= 24; i++) begin
      gen_next(b);
      send(1, b, 0);
      if (i == 23) chk({tag, "_unlocked_at_23"}, bus_a.locked, 0);
      if (i == 24) chk({tag, "_locked_at_24"}, bus_a.locked, 1);
    end
  endtask

  initial begin
    bit b;
    int pulses, lost_seen, acc;
    bus_a.din_valid = 1'b0;
    bus_a.din       = 1'b0;
    bus_a.clr_err   = 1'b0;
    model_reset();
    model_on = 1'b1;
    #2;
    chk("reset_locked", bus_a.locked, 0);
    chk("reset_err_cnt", bus_a.err_cnt, 0);

    // Clean lock and 1000 error-free bits; first bits must be 1,1,1,1,1,0.
    do_reset();
    g = 8'h00;
    for (int i = 0; i < 6; i++) gen_next(b);
    chk("gen_first6", g[5:0], 6'b111110);
    g = 8'h00;
    lock_clean("clean");
    pulses = 0;
    for (int i = 0; i < 976; i++) begin
      gen_next(b);
      send(1, b, 0);
      if (bus_a.err_pulse || bus_a.lock_lost) pulses++;
    end
    chk("clean_err_cnt", bus_a.err_cnt, 0);
    chk("clean_no_pulses", pulses, 0);

    // Single inverted bit.
    gen_next(b);
    send(1, ~b, 0);
    chk("single_pulse", bus_a.err_pulse, 1);
    chk("single_cnt", bus_a.err_cnt, 1);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      gen_next(b);
      send(1, b, 0);
      if (bus_a.err_pulse) pulses++;
    end
    chk("single_no_more", pulses, 0);
    chk("single_still_locked", bus_a.locked, 1);
    chk("single_cnt_after", bus_a.err_cnt, 1);

    // Bit slip: drop one generator bit.
    gen_next(b);
    lost_seen = 0;
    for (int i = 0; i < 200; i++) begin
      gen_next(b);
      send(1, b, 0);
      if (bus_a.lock_lost) lost_seen++;
    end
    chk("slip_lost_once", lost_seen, 1);
    chk("slip_relocked", bus_a.locked, 1);
    chk("slip_cnt_ge5", (bus_a.err_cnt >= 5) ? 1 : 0, 1);

    // Gapped valid at ~30% duty.
    do_reset();
    acc = 0;
    while (acc < 300) begin
      if ($urandom_range(99) < 30) begin
        gen_next(b);
        send(1, b, 0);
        acc++;
        if (acc == 23) chk("gap_unlocked_at_23", bus_a.locked, 0);
        if (acc == 24) chk("gap_locked_at_24", bus_a.locked, 1);
      end else begin
        send(0, 1'($urandom_range(1)), 0);
      end
    end
    chk("gap_err_cnt", bus_a.err_cnt, 0);

    // Every 40th bit inverted: 4-bit counter saturates.
    do_reset();
    lock_clean("sat");
    for (int i = 0; i < 800; i++) begin
      gen_next(b);
      send(1, (i % 40 == 39) ? ~b : b, 0);
    end
    chk("sat_cnt16", bus_a.err_cnt, 20);
    chk("sat_cnt4", bus_b.err_cnt, 15);
    chk("sat_locked", bus_a.locked, 1);

    // Clear together with an error.
    gen_next(b);
    send(1, ~b, 1);
    chk("clr_pulse", bus_a.err_pulse, 1);
    chk("clr_cnt16", bus_a.err_cnt, 0);
    chk("clr_cnt4", bus_b.err_cnt, 0);

    // Reach err_cnt=3 then reset mid-operation.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin gen_next(b); send(1, b, 0); end
      gen_next(b);
      send(1, ~b, 0);
    end
    gen_next(b);
    send(1, b, 0);
    chk("pre_reset_cnt", bus_a.err_cnt, 3);
    chk("pre_reset_locked", bus_a.locked, 1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_rst_locked", bus_a.locked, 0);
    chk("async_rst_cnt", bus_a.err_cnt, 0);
    send(0, 0, 0);
    send(0, 0, 0);
    rst = 1'b1;
    g = 8'h00;
    lock_clean("relock");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
